// File: rtl/fp_pkg.sv
// Shared single-precision constants and the stage-A pipeline record for the
// multiplier's normalise/round/pack stage.
package fp_pkg;

    localparam int FP_BIAS   = 127;
    localparam int EXP_MAX   = 255;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_MANT_W = FP_FRAC_W + 1;

    // Internal exponent is one bit wider than the 10-bit sum so +1/+carry never wrap.
    localparam int SA_EXP_W  = 11;

    typedef struct packed {
        logic                       sign;
        logic signed [SA_EXP_W-1:0] exp;
        logic [FP_MANT_W-1:0]       mant24;
        logic                       guard;
        logic                       sticky;
        logic                       nan;
        logic                       inf;
        logic                       zero;
    } fp_stageA_t;

    function automatic logic [31:0] fp_pack(input logic sign,
                                            input logic [FP_EXP_W-1:0] exp,
                                            input logic [FP_FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a 24-bit significand with guard and sticky bits.
module fp_rne_round
    import fp_pkg::*;
(
    input  logic [FP_MANT_W-1:0] mant_in,
    input  logic                 guard,
    input  logic                 sticky,
    output logic [FP_MANT_W-1:0] mant_out,
    output logic                 carry,
    output logic                 inexact
);

    logic                 round_up;
    logic [FP_MANT_W:0]   sum;

    always_comb begin
        round_up = guard & (sticky | mant_in[0]);
        sum      = {1'b0, mant_in} + {{FP_MANT_W{1'b0}}, round_up};
        carry    = sum[FP_MANT_W];
        // 1.111..1 + ulp becomes 10.000..0: renormalise to 1.0, exponent bumps outside.
        mant_out = carry ? {1'b1, {(FP_MANT_W-1){1'b0}}} : sum[FP_MANT_W-1:0];
        inexact  = guard | sticky;
    end

endmodule

// File: rtl/fpm_round_norm.sv
// Two-stage normalise (A) and round/pack (B) pipeline behind the FP32 multiplier.
// Handshake: a beat transfers when valid & ready; each stage advances when empty or downstream advances.
module fpm_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = 10,
    parameter int MAN_W = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] man_prod,
    input  logic [EXP_W-1:0] exp_sum,
    input  logic             sign_in,
    input  logic             is_nan,
    input  logic             is_inf,
    input  logic             is_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inx
);

    localparam logic signed [SA_EXP_W-1:0] EXP_ONE  = SA_EXP_W'(1);
    localparam logic signed [SA_EXP_W-1:0] EXP_NIL  = SA_EXP_W'(0);
    localparam logic signed [SA_EXP_W-1:0] EXP_OVF  = SA_EXP_W'(EXP_MAX);

    logic       adv_a, adv_b;
    logic       va_q, va_d, vb_q, vb_d;
    fp_stageA_t a_q, a_d, a_new;
    logic [31:0] result_q, result_d;
    logic       ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    logic signed [SA_EXP_W-1:0] exp_ext;
    logic signed [SA_EXP_W-1:0] exp_r;
    logic [FP_MANT_W-1:0]       mant_r;
    logic                       carry_r, inexact_r;
    logic [31:0]                res_w;
    logic                       ovf_w, unf_w, inx_w;
    logic                       unused_hidden;

    assign adv_b     = !vb_q || out_ready;
    assign adv_a     = !va_q || adv_b;
    assign in_ready  = adv_a;
    assign out_valid = vb_q;
    assign result    = result_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;
    assign flag_inx  = inx_q;

    // Stage A: align the product so the hidden bit sits at mant24[23].
    always_comb begin
        exp_ext      = SA_EXP_W'(signed'(exp_sum));
        a_new        = '0;
        a_new.sign   = sign_in;
        a_new.nan    = is_nan;
        a_new.inf    = is_inf;
        a_new.zero   = is_zero;
        if (man_prod[MAN_W-1]) begin
            a_new.mant24 = man_prod[MAN_W-1 -: FP_MANT_W];
            a_new.guard  = man_prod[MAN_W-25];
            a_new.sticky = |man_prod[MAN_W-26:0];
            a_new.exp    = exp_ext + EXP_ONE;
        end else begin
            a_new.mant24 = man_prod[MAN_W-2 -: FP_MANT_W];
            a_new.guard  = man_prod[MAN_W-26];
            a_new.sticky = |man_prod[MAN_W-27:0];
            a_new.exp    = exp_ext;
        end
    end

    fp_rne_round u_round (
        .mant_in  (a_q.mant24),
        .guard    (a_q.guard),
        .sticky   (a_q.sticky),
        .mant_out (mant_r),
        .carry    (carry_r),
        .inexact  (inexact_r)
    );

    assign unused_hidden = mant_r[FP_MANT_W-1];

    // Stage B: special operands win, then range limits, then the normal packed value.
    always_comb begin
        res_w = '0;
        ovf_w = 1'b0;
        unf_w = 1'b0;
        inx_w = 1'b0;
        exp_r = a_q.exp + (carry_r ? EXP_ONE : EXP_NIL);
        if (a_q.nan || (a_q.inf && a_q.zero)) begin
            res_w = QNAN;
        end else if (a_q.inf) begin
            res_w = fp_pack(a_q.sign, '1, '0);
        end else if (a_q.zero) begin
            res_w = fp_pack(a_q.sign, '0, '0);
        end else if (exp_r >= EXP_OVF) begin
            res_w = fp_pack(a_q.sign, '1, '0);
            ovf_w = 1'b1;
            inx_w = 1'b1;
        end else if (exp_r <= EXP_NIL) begin
            res_w = fp_pack(a_q.sign, '0, '0);
            unf_w = 1'b1;
            inx_w = 1'b1;
        end else begin
            res_w = fp_pack(a_q.sign, exp_r[FP_EXP_W-1:0], mant_r[FP_FRAC_W-1:0]);
            inx_w = inexact_r;
        end
    end

    always_comb begin
        va_d     = adv_a ? in_valid : va_q;
        a_d      = (adv_a && in_valid) ? a_new : a_q;
        vb_d     = adv_b ? va_q : vb_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        if (adv_b && va_q) begin
            result_d = res_w;
            ovf_d    = ovf_w;
            unf_d    = unf_w;
            inx_d    = inx_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q     <= 1'b0;
            vb_q     <= 1'b0;
            a_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            va_q     <= va_d;
            vb_q     <= vb_d;
            a_q      <= a_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            inx_q    <= inx_d;
        end
    end

endmodule
